// File: rtl/doodle_pkg.sv
// Shared definitions for the doodle game sprites: game-state encoding,
// the overlay sequencer state type and screen geometry constants.
package doodle_pkg;

  typedef logic [1:0] game_state_t;

  localparam game_state_t GAME_OVER = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SLIDE,
    HOLD,
    READY
  } overlay_state_t;

  // Screen geometry (800x600 visible area)
  localparam int unsigned BEAM_X_W         = 11;
  localparam int unsigned BEAM_Y_W         = 10;
  localparam int unsigned V_ACTIVE         = 600;
  // First vertical-blanking line; used as the per-frame update point
  localparam int unsigned FRAME_START_LINE = V_ACTIVE;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: registered one-cycle frame tick, high for the single cycle
// after the beam sits at column 0 of line FRAME_START_Y.
// Ports:
//   i_clk     clock
//   i_rst_n   synchronous active-low reset
//   i_beam_x  current beam column
//   i_beam_y  current beam line
//   o_tick    one-cycle frame tick
module frame_tick_gen #(
  parameter int unsigned X_W           = 11,
  parameter int unsigned Y_W           = 10,
  parameter int unsigned FRAME_START_Y = 600
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [X_W-1:0] i_beam_x,
  input  logic [Y_W-1:0] i_beam_y,
  output logic           o_tick
);

  logic w_match;
  logic r_tick;

  always_comb begin
    w_match = (i_beam_x == '0) && (i_beam_y == Y_W'(FRAME_START_Y));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_match;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/game_over_overlay_ctrl.sv
// game_over_overlay_ctrl: sequencer for the game-over signature overlay.
// Per game-over episode: arm, slide the sprite in from SLIDE_START lines down,
// hold for HOLD_FRAMES frames, then offer a restart to the game FSM.
// All visible updates happen on the frame tick (vertical blanking).
// Optional feature macro: OVERLAY_BLINK_EN (blink overlay_en while READY).
// Ports:
//   clk               clock
//   rst               synchronous active-low reset
//   game_state        current game FSM state
//   beam_x, beam_y    current beam position
//   restart_req       level request to leave game over
//   overlay_en        sprite renderer enable
//   overlay_y_offset  lines added to the sprite top Y (0 = final position)
//   restart_ready     high while a restart is accepted
//   restart_ack       one-cycle pulse when a restart is accepted
module game_over_overlay_ctrl
  import doodle_pkg::*;
#(
  parameter game_state_t GAME_OVER_STATE = GAME_OVER,
  parameter int unsigned FRAME_START_Y   = FRAME_START_LINE,
  parameter int unsigned SLIDE_START     = 282,
  parameter int unsigned SLIDE_STEP      = 6,
  parameter int unsigned HOLD_FRAMES     = 60,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic [10:0] beam_x,
  input  logic [9:0]  beam_y,
  input  logic        restart_req,
  output logic        overlay_en,
  output logic [9:0]  overlay_y_offset,
  output logic        restart_ready,
  output logic        restart_ack
);

  localparam int unsigned CNT_MAX = max_u(HOLD_FRAMES, BLINK_FRAMES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [9:0]       OFF_START = 10'(SLIDE_START);
  localparam logic [9:0]       OFF_STEP  = 10'(SLIDE_STEP);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
`ifdef OVERLAY_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
`endif

  overlay_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en;
  logic [9:0]       r_off;
  logic             r_ready;
  logic             r_ack;

  logic w_tick;
  logic w_abort;

  frame_tick_gen #(
    .X_W           (BEAM_X_W),
    .Y_W           (BEAM_Y_W),
    .FRAME_START_Y (FRAME_START_Y)
  ) u_tick (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_beam_x (beam_x),
    .i_beam_y (beam_y),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_abort = (game_state != GAME_OVER_STATE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_off   <= OFF_START;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      // Abort outranks both the frame tick and a pending restart request
      if ((r_state != IDLE) && w_abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_en    <= 1'b0;
        r_off   <= OFF_START;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_off   <= OFF_START;
            r_ready <= 1'b0;
            if (!w_abort) begin
              r_state <= ARM;
            end
          end
          ARM: begin
            if (w_tick) begin
              r_en    <= 1'b1;
              r_state <= SLIDE;
            end
          end
          SLIDE: begin
            if (w_tick) begin
              // Saturate at 0; reaching 0 ends the slide on this same tick
              if (r_off <= OFF_STEP) begin
                r_off   <= '0;
                r_cnt   <= '0;
                r_state <= HOLD;
              end else begin
                r_off <= r_off - OFF_STEP;
              end
            end
          end
          HOLD: begin
            if (w_tick) begin
              if (r_cnt == HOLD_LAST) begin
                r_cnt   <= '0;
                r_ready <= 1'b1;
                r_state <= READY;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          READY: begin
            if (restart_req) begin
              // Ack pulses on the same edge the outputs fall back to idle values
              r_ack   <= 1'b1;
              r_state <= IDLE;
              r_cnt   <= '0;
              r_en    <= 1'b0;
              r_off   <= OFF_START;
              r_ready <= 1'b0;
            end
`ifdef OVERLAY_BLINK_EN
            else if (w_tick) begin
              if (r_cnt == BLINK_LAST) begin
                r_en  <= ~r_en;
                r_cnt <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
`endif
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign overlay_en       = r_en;
  assign overlay_y_offset = r_off;
  assign restart_ready    = r_ready;
  assign restart_ack      = r_ack;

endmodule

// File: tb/tb_game_over_overlay_ctrl.sv
module tb_game_over_overlay_ctrl;

  typedef struct packed {
    logic       en;
    logic [9:0] off;
    logic       rdy;
    logic       ack;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [1:0]  gs_a;
  logic [1:0]  gs_b;
  logic [10:0] bx;
  logic [9:0]  by;
  logic        req;

  logic       en_a, rdy_a, ack_a;
  logic [9:0] off_a;
  logic       en_b, rdy_b, ack_b;
  logic [9:0] off_b;

  int unsigned n_checks;
  int unsigned n_pass;
  obs_t        sb[$];
  obs_t        cur[2];

  game_over_overlay_ctrl dut_a (
    .clk              (clk),
    .rst              (rst),
    .game_state       (gs_a),
    .beam_x           (bx),
    .beam_y           (by),
    .restart_req      (req),
    .overlay_en       (en_a),
    .overlay_y_offset (off_a),
    .restart_ready    (rdy_a),
    .restart_ack      (ack_a)
  );

  game_over_overlay_ctrl #(.SLIDE_START(10)) dut_b (
    .clk              (clk),
    .rst              (rst),
    .game_state       (gs_b),
    .beam_x           (bx),
    .beam_y           (by),
    .restart_req      (req),
    .overlay_en       (en_b),
    .overlay_y_offset (off_b),
    .restart_ready    (rdy_b),
    .restart_ack      (ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{en: en_a, off: off_a, rdy: rdy_a, ack: ack_a};
    else          o = '{en: en_b, off: off_b, rdy: rdy_b, ack: ack_b};
    return o;
  endfunction

  function automatic obs_t mk(input logic en, input int off, input logic rdy, input logic ack);
    obs_t o;
    o = '{en: en, off: 10'(off), rdy: rdy, ack: ack};
    return o;
  endfunction

  task automatic check_obs(input int sel, input string tag, input obs_t e);
    obs_t g;
    g = obs(sel);
    check_eq({tag, ".en"},  32'(g.en),  32'(e.en));
    check_eq({tag, ".off"}, 32'(g.off), 32'(e.off));
    check_eq({tag, ".rdy"}, 32'(g.rdy), 32'(e.rdy));
    check_eq({tag, ".ack"}, 32'(g.ack), 32'(e.ack));
  endtask

  task automatic compare_pop(input int sel, input string tag);
    obs_t e;
    e = sb.pop_front();
    check_obs(sel, tag, e);
    cur[sel] = e;
  endtask

  task automatic expect_now(input int sel, input string tag, input obs_t e);
    sb.push_back(e);
    compare_pop(sel, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beam(input int x, input int y);
    bx = 11'(x);
    by = 10'(y);
  endtask

  // One compressed frame: beam match, near misses, then idle coordinates.
  // Expected outputs move exactly two edges after the match and stay put otherwise.
  task automatic run_frame(input int sel, input string tag, input obs_t e);
    obs_t old;
    old = cur[sel];
    sb.push_back(e);
    beam(0, 600); step();
    check_obs(sel, {tag, ".pre"}, old);
    beam(1, 600); step();
    compare_pop(sel, tag);
    beam(0, 599); step();
    check_obs(sel, {tag, ".st1"}, e);
    beam(2, 0);   step();
    check_obs(sel, {tag, ".st2"}, e);
    beam(3, 3);
  endtask

  // From ARM: enable frame, slide to 0, HOLD frames up to READY.
  // restart_req is pulsed in SLIDE and HOLD; it must be ignored there.
  task automatic run_to_ready(input int sel, input int start, input int stop_off);
    int off;
    off = start;
    run_frame(sel, "enable", mk(1'b1, off, 1'b0, 1'b0));
    for (int i = 1; off != 0 && off != stop_off; i++) begin
      req = (i >= 5 && i <= 7);
      off = (off < 6) ? 0 : off - 6;
      run_frame(sel, "slide", mk(1'b1, off, 1'b0, 1'b0));
    end
    req = 1'b0;
    if (off == 0) begin
      for (int k = 1; k <= 60; k++) begin
        req = (k == 10 || k == 11);
        run_frame(sel, "hold", mk(1'b1, 0, (k == 60), 1'b0));
      end
    end
    req = 1'b0;
  endtask

  initial begin
    obs_t rst_a;
    obs_t rst_b;
    logic e_en;
    n_checks = 0;
    n_pass   = 0;
    rst_a = mk(1'b0, 282, 1'b0, 1'b0);
    rst_b = mk(1'b0, 10,  1'b0, 1'b0);

    rst  = 1'b0;
    gs_a = 2'd2;
    gs_b = 2'd2;
    req  = 1'b0;
    beam(3, 3);
    repeat (3) step();
    expect_now(0, "reset_a", rst_a);
    expect_now(1, "reset_b", rst_b);

    // Main episode on A: arm, slide 282..0, hold 60, READY
    gs_b = 2'd0;
    rst  = 1'b1;
    step();
    expect_now(0, "arm", rst_a);
    run_to_ready(0, 282, -1);

    for (int k = 1; k <= 100; k++) begin
`ifdef OVERLAY_BLINK_EN
      e_en = ((k / 30) % 2 == 0);
`else
      e_en = 1'b1;
`endif
      run_frame(0, "ready", mk(e_en, 0, 1'b1, 1'b0));
    end

    // Restart handshake: request held 5 cycles, single ack
    req = 1'b1;
    step();
    expect_now(0, "ack", mk(1'b0, 282, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      step();
      expect_now(0, "post_ack", rst_a);
    end
    req  = 1'b0;
    gs_a = 2'd0;
    step();
    expect_now(0, "idle", rst_a);

    // Abort during SLIDE at offset 150, coinciding with a tick
    gs_a = 2'd2;
    step();
    run_to_ready(0, 282, 150);
    check_eq("slide_at_150", 32'(off_a), 32'd150);
    beam(0, 600); step();
    check_obs(0, "abort.pre", cur[0]);
    gs_a = 2'd1;
    beam(1, 600); step();
    expect_now(0, "abort", rst_a);
    gs_a = 2'd2;
    beam(3, 3); step();
    expect_now(0, "rearm", rst_a);
    run_to_ready(0, 282, -1);

    // Abort in READY together with restart_req: no ack
    gs_a = 2'd0;
    req  = 1'b1;
    step();
    expect_now(0, "abort_req", rst_a);
    step();
    expect_now(0, "abort_req2", rst_a);
    req = 1'b0;

    // Saturating slide on B: 10, 4, 0 then HOLD
    gs_b = 2'd2;
    step();
    expect_now(1, "b_arm", rst_b);
    run_frame(1, "b_en",  mk(1'b1, 10, 1'b0, 1'b0));
    run_frame(1, "b_s1",  mk(1'b1, 4,  1'b0, 1'b0));
    run_frame(1, "b_s2",  mk(1'b1, 0,  1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      run_frame(1, "b_hold", mk(1'b1, 0, 1'b0, 1'b0));
    end
    gs_b = 2'd0;
    step();
    expect_now(1, "b_abort", rst_b);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
